pc_fetch: RTL and testbench
===========================

# pc_fetch

Instruction-fetch stage of the pipelined CPU. It owns the program counter and the IF/ID pipeline register. It consumes the `Pcsrc`/`Condep` decision produced by the PC-source controller, computes the next PC, and drives the instruction-memory address. It inserts bubbles on jumps and taken branches, and holds state under hazard stalls.

## Interface
Parameters:
- `ADDR_W`, 32: PC and address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pcsrc`, in, 2: next-PC select from the PC-source controller.
- `condep`, in, 1: 0 means a taken branch is resolved in EX, so flush younger stages.
- `br_target`, in, ADDR_W: branch target computed in EX.
- `stall`, in, 1: hazard stall. Freezes the PC and IF/ID.
- `imem_addr`, out, ADDR_W: instruction-memory address. Equal to the PC register. Memory read is asynchronous.
- `imem_rdata`, in, 32: instruction word at `imem_addr`, valid in the same cycle.
- `ifid_instr`, out, 32: registered instruction presented to ID.
- `ifid_pc4`, out, ADDR_W: registered PC+4 of `ifid_instr`.
- `ifid_valid`, out, 1: `ifid_instr` is a real instruction, not a bubble.
- `id_flush`, out, 1: combinational. Equals `~condep`. Tells ID/EX to squash its input.
- `pcsrc_err`, out, 1: sticky flag, set when a reserved `pcsrc` code is seen.

## Operation
`pcsrc` encodings:
- 00: sequential, next PC = PC+4.
- 10: branch, next PC = `br_target`.
- 11: jump, next PC = {`ifid_pc4`[ADDR_W-1:28], `ifid_instr`[25:0], 2'b00}.
- 01: reserved. Behaves as 00 and sets `pcsrc_err`.

Per-edge update, highest priority first:
1. **Branch taken** (`condep`=0 and `pcsrc`=10). Stall is ignored.
   - PC <= `br_target`.
   - IF/ID <= bubble: `ifid_instr`=32'h0 (NOP), `ifid_valid`=0, `ifid_pc4` unchanged.
2. **Stall** (`stall`=1). PC and all IF/ID fields hold.
   - A jump (`pcsrc`=11) present during a stall is not taken. It is re-presented by ID once the stall drops.
3. **Jump** (`pcsrc`=11 and `ifid_valid`=1).
   - PC <= jump target.
   - IF/ID <= bubble. There is no delay slot.
4. **Sequential** (otherwise).
   - PC <= PC+4.
   - `ifid_instr` <= `imem_rdata`, `ifid_pc4` <= PC+4, `ifid_valid` <= 1.

Corner cases:
- `pcsrc`=11 with `ifid_valid`=0 is treated as sequential. A bubble cannot jump.
- `condep`=0 with `pcsrc`≠10 cannot occur legally. It is treated as sequential, and `id_flush` still follows `~condep`.
- PC+4 wraps modulo 2^ADDR_W: 0xFFFF_FFFC goes to 0x0000_0000. No trap.
- Misaligned `br_target` has its low two bits forced to 00.

## Timing
- Reset (async assert, synchronous-release use): PC=`RESET_PC`, `ifid_instr`=0, `ifid_pc4`=0, `ifid_valid`=0, `pcsrc_err`=0.
- The first fetch is at `RESET_PC` in the first cycle after `rst_n` rises. `ifid_valid` first goes to 1 one cycle later.
- Redirect latency is 1 edge. A decision presented in cycle N gives `imem_addr` = target in cycle N+1.
- Redirect penalties:
  - Taken branch: 2 bubbles total. The IF/ID bubble comes from this block; the ID/EX bubble comes from `id_flush`.
  - Jump: 1 bubble.
- `id_flush` is purely combinational, with no register delay.
- Reset asserted mid-stall or mid-redirect overrides everything immediately.

## Configuration
Macro `PC_FETCH_REDIRECT_CNT_EN`:
- **When defined**, the block adds outputs `br_cnt[15:0]` and `jmp_cnt[15:0]`.
  - These count taken branches and taken jumps.
  - Both saturate at 16'hFFFF, reset to 0, and hold during stall.
- **When undefined**, these ports and their logic are absent. Core behaviour is identical in both builds.

## Structure
- Shared package `cpu_pkg`:
  - `pcsrc` localparams `PCSRC_SEQ`=2'b00, `PCSRC_RSV`=2'b01, `PCSRC_BR`=2'b10, `PCSRC_JMP`=2'b11.
  - `NOP_INSTR`=32'h0.
  - Opcode constants `OP_J`=6'b000010, `OP_BEQ`=6'b000100, `OP_BNE`=6'b000101.
- Sub-module `pc_next_mux`: combinational next-PC select covering PC+4, branch, jump concatenation and reserved-code handling. The top level keeps the registers and priority logic.

## Test plan
1. **Reset and sequential fetch.** Pulse `rst_n` low, then run 4 cycles with `pcsrc`=00.
   - `imem_addr` = 0, 4, 8, C.
   - `ifid_pc4` = 4, 8, C, one cycle behind.
   - `ifid_valid` = 1 from the 2nd cycle.
2. **Taken branch under stall.** Hold `stall`=1, `pcsrc`=10, `condep`=0, `br_target`=0x40.
   - `id_flush`=1 in the same cycle.
   - Next cycle: `imem_addr`=0x40, `ifid_valid`=0, `ifid_instr`=0.
3. **Jump delayed by stall.** `ifid_instr`=0x0800_0010, `ifid_pc4`=0x0000_0104, `pcsrc`=11, `stall`=1 for 2 cycles, then 0.
   - PC holds during the stall.
   - Then `imem_addr`=0x0000_0040, and one bubble is seen in IF/ID.
4. **Reserved code.** Apply `pcsrc`=01 at PC=0x10.
   - `imem_addr`=0x14 next cycle.
   - `pcsrc_err`=1 and stays 1 until reset.
5. **Wrap-around and async reset.**
   - Branch to 0xFFFF_FFFC, then run sequentially: `imem_addr`=0x0.
   - Drop `rst_n` mid-cycle: PC=`RESET_PC` and `ifid_valid`=0 without waiting for a clock edge.
6. **Redirect counters** (`PC_FETCH_REDIRECT_CNT_EN` defined). Force 65 540 taken branches.
   - `br_cnt`=16'hFFFF.
   - `jmp_cnt`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pcsrc encodings, NOP word and opcode constants for the CPU pipeline
package cpu_pkg;
  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_RSV = 2'b01;
  localparam logic [1:0] PCSRC_BR  = 2'b10;
  localparam logic [1:0] PCSRC_JMP = 2'b11;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC candidate (PC+4, aligned branch target, jump concatenation)
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic [1:0]         pcsrc,
  input  logic [ADDR_W-29:0] pc4_hi,
  input  logic [25:0]        jidx,
  output logic [ADDR_W-1:0]  pc4,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               rsv
);
  always_comb begin
    pc4 = pc + ADDR_W'(4);
    next_pc = pcsrc == PCSRC_BR  ? br_target & ~ADDR_W'(3) :
              pcsrc == PCSRC_JMP ? {pc4_hi, jidx, 2'b00} : pc4;
    rsv = pcsrc == PCSRC_RSV;
  end
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC register and IF/ID pipeline register with branch/jump redirect and stall hold
// PC_FETCH_REDIRECT_CNT_EN adds saturating br_cnt/jmp_cnt redirect counters
module pc_fetch
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        pcsrc,
  input  logic              condep,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              stall,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              ifid_valid,
  output logic              id_flush,
  output logic              pcsrc_err
`ifdef PC_FETCH_REDIRECT_CNT_EN
  ,
  output logic [15:0]       br_cnt,
  output logic [15:0]       jmp_cnt
`endif
);
  logic [ADDR_W-1:0] pc, pc4, next_pc;
  logic rsv, take_br, take_jmp;

  pc_next_mux #(.ADDR_W(ADDR_W)) u_mux (
    .pc(pc), .br_target(br_target), .pcsrc(pcsrc),
    .pc4_hi(ifid_pc4[ADDR_W-1:28]), .jidx(ifid_instr[25:0]),
    .pc4(pc4), .next_pc(next_pc), .rsv(rsv)
  );

  assign imem_addr = pc;
  assign id_flush  = ~condep;
  assign take_br   = ~condep & (pcsrc == PCSRC_BR);
  // a bubble in IF/ID carries no jump, and a stalled jump is re-presented later
  assign take_jmp  = ~stall & ifid_valid & (pcsrc == PCSRC_JMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
      pcsrc_err  <= 1'b0;
    end else begin
      if (rsv) pcsrc_err <= 1'b1;
      if (take_br) begin
        pc         <= next_pc;
        ifid_instr <= NOP_INSTR;
        ifid_valid <= 1'b0;
      end else if (!stall) begin
        pc         <= take_jmp ? next_pc : pc4;
        ifid_instr <= take_jmp ? NOP_INSTR : imem_rdata;
        ifid_valid <= ~take_jmp;
        if (!take_jmp) ifid_pc4 <= pc4;
      end
    end
  end

`ifdef PC_FETCH_REDIRECT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt  <= '0;
      jmp_cnt <= '0;
    end else begin
      if (take_br && br_cnt != 16'hFFFF) br_cnt <= br_cnt + 16'd1;
      if (take_jmp && jmp_cnt != 16'hFFFF) jmp_cnt <= jmp_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed self-checking bench for pc_fetch
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  pcsrc = 2'b00;
  logic        condep = 1'b1;
  logic [31:0] br_target = '0;
  logic        stall = 1'b0;
  logic [31:0] imem_addr, imem_rdata, ifid_instr, ifid_pc4;
  logic        ifid_valid, id_flush, pcsrc_err;
  int          n_chk = 0, n_pass = 0;
`ifdef PC_FETCH_REDIRECT_CNT_EN
  logic [15:0] br_cnt, jmp_cnt;
`endif

  pc_fetch dut (
    .clk(clk), .rst_n(rst_n), .pcsrc(pcsrc), .condep(condep), .br_target(br_target),
    .stall(stall), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .id_flush(id_flush), .pcsrc_err(pcsrc_err)
`ifdef PC_FETCH_REDIRECT_CNT_EN
    , .br_cnt(br_cnt), .jmp_cnt(jmp_cnt)
`endif
  );

  always #5 clk = ~clk;

  // 0x100 holds a J with index 0x10; everything else is a tagged filler word
  assign imem_rdata = imem_addr == 32'h100 ? 32'h0800_0010 : {16'hA5A5, imem_addr[15:0]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(ifid_valid), 0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc4", ifid_pc4, 32'h0);
    chk("rst_err", 32'(pcsrc_err), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", imem_addr, 32'(4 * i));
      step();
      chk("seq_pc4", ifid_pc4, 32'(4 * (i + 1)));
      chk("seq_valid", 32'(ifid_valid), 1);
      chk("seq_instr", ifid_instr, {16'hA5A5, 16'(4 * i)});
    end
    pcsrc = 2'b01;
    chk("rsv_err_pre", 32'(pcsrc_err), 0);
    step();
    chk("rsv_addr", imem_addr, 32'h14);
    chk("rsv_err", 32'(pcsrc_err), 1);
    pcsrc = 2'b00;
    step();
    chk("rsv_sticky", 32'(pcsrc_err), 1);
    chk("rsv_seq", imem_addr, 32'h18);
    stall = 1'b1; pcsrc = 2'b10; condep = 1'b0; br_target = 32'h43;
    #1;
    chk("br_flush", 32'(id_flush), 1);
    step();
    chk("br_addr", imem_addr, 32'h40);
    chk("br_valid", 32'(ifid_valid), 0);
    chk("br_instr", ifid_instr, 32'h0);
    chk("br_pc4", ifid_pc4, 32'h18);
    stall = 1'b0; pcsrc = 2'b00; condep = 1'b1;
    #1;
    chk("noflush", 32'(id_flush), 0);
    pcsrc = 2'b10; condep = 1'b0; br_target = 32'h100;
    step();
    pcsrc = 2'b00; condep = 1'b1;
    step();
    chk("j_instr", ifid_instr, 32'h0800_0010);
    chk("j_pc4", ifid_pc4, 32'h104);
    pcsrc = 2'b11; stall = 1'b1;
    step();
    chk("j_hold1", imem_addr, 32'h104);
    step();
    chk("j_hold2", imem_addr, 32'h104);
    chk("j_hold_instr", ifid_instr, 32'h0800_0010);
    stall = 1'b0;
    step();
    chk("j_addr", imem_addr, 32'h40);
    chk("j_valid", 32'(ifid_valid), 0);
    chk("j_instr0", ifid_instr, 32'h0);
    step();
    chk("j_bubble_seq", imem_addr, 32'h44);
    chk("j_bubble_valid", 32'(ifid_valid), 1);
    pcsrc = 2'b00;
`ifdef PC_FETCH_REDIRECT_CNT_EN
    chk("cnt_br_small", 32'(br_cnt), 2);
    chk("cnt_jmp_small", 32'(jmp_cnt), 1);
`endif
    pcsrc = 2'b10; condep = 1'b0; br_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    pcsrc = 2'b00; condep = 1'b1;
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4", ifid_pc4, 32'h0);
    step();
    chk("wrap_next", imem_addr, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_valid", 32'(ifid_valid), 0);
    chk("arst_err", 32'(pcsrc_err), 0);
`ifdef PC_FETCH_REDIRECT_CNT_EN
    step();
    rst_n = 1'b1;
    pcsrc = 2'b10; condep = 1'b0; br_target = 32'h0;
    repeat (65540) step();
    chk("cnt_br_sat", 32'(br_cnt), 32'hFFFF);
    chk("cnt_jmp", 32'(jmp_cnt), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
